// File: rtl/mips_alu_pkg.sv
// Shared opcode encodings and engine state type for the sequential MIPS ALU.
package mips_alu_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] ALU_AND   = 4'd0;
  localparam logic [OP_W-1:0] ALU_OR    = 4'd1;
  localparam logic [OP_W-1:0] ALU_ADD   = 4'd2;
  localparam logic [OP_W-1:0] ALU_SLTU  = 4'd3;
  localparam logic [OP_W-1:0] ALU_SLL   = 4'd4;
  localparam logic [OP_W-1:0] ALU_SRL   = 4'd5;
  localparam logic [OP_W-1:0] ALU_SUB   = 4'd6;
  localparam logic [OP_W-1:0] ALU_SLT   = 4'd7;
  localparam logic [OP_W-1:0] ALU_MULT  = 4'd8;
  localparam logic [OP_W-1:0] ALU_MULTU = 4'd9;
  localparam logic [OP_W-1:0] ALU_DIV   = 4'd10;
  localparam logic [OP_W-1:0] ALU_DIVU  = 4'd11;
  localparam logic [OP_W-1:0] ALU_NOR   = 4'd12;
  localparam logic [OP_W-1:0] ALU_XOR   = 4'd13;
  localparam logic [OP_W-1:0] ALU_SRA   = 4'd14;
  localparam logic [OP_W-1:0] ALU_NOP   = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } md_state_e;

  // Codes 8..11 run on the iterative multiply/divide engine.
  function automatic logic is_muldiv(input logic [OP_W-1:0] op);
    return (op[3:2] == 2'b10);
  endfunction

endpackage

// File: rtl/mips_muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider producing HI/LO.
// Operates on magnitudes; signs are reapplied on the final iteration step.
module mips_muldiv_unit
  import mips_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [OP_W-1:0]  i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_divzero,
  output logic             o_ovf
);

  localparam int unsigned SH_W = $clog2(WIDTH);
  localparam int unsigned PW   = 2 * WIDTH;
  localparam logic [SH_W-1:0]  LAST_STEP = SH_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL   = {1'b1, {(WIDTH-1){1'b0}}};

  md_state_e r_state, w_state_next;

  logic [WIDTH-1:0] r_acc, r_q, r_m;
  logic [SH_W-1:0]  r_cnt;
  logic             r_is_div, r_neg_q, r_neg_r, r_divzero, r_ovf;

  logic             w_signed, w_div, w_dz, w_min_ovf, w_last, w_ge;
  logic [WIDTH-1:0] w_abs_a, w_abs_b;
  logic [WIDTH:0]   w_sum, w_shift, w_trial;
  logic [WIDTH-1:0] w_acc_step, w_q_step, w_hi_fix, w_lo_fix;
  logic [PW-1:0]    w_prod;

  assign w_signed  = (i_op == ALU_MULT) || (i_op == ALU_DIV);
  assign w_div     = (i_op == ALU_DIV) || (i_op == ALU_DIVU);
  assign w_abs_a   = (w_signed && i_a[WIDTH-1]) ? (~i_a + WIDTH'(1)) : i_a;
  assign w_abs_b   = (w_signed && i_b[WIDTH-1]) ? (~i_b + WIDTH'(1)) : i_b;
  assign w_dz      = w_div && (i_b == '0);
  assign w_min_ovf = (i_op == ALU_DIV) && (i_a == MIN_VAL) && (i_b == '1);
  assign w_last    = (r_cnt == LAST_STEP);

  // One iteration step plus the sign fix-up applied on the last step.
  always_comb begin
    w_sum      = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : {(WIDTH+1){1'b0}});
    w_shift    = {r_acc, r_q[WIDTH-1]};
    w_trial    = w_shift - {1'b0, r_m};
    w_ge       = ~w_trial[WIDTH];
    w_acc_step = w_sum[WIDTH:1];
    w_q_step   = {w_sum[0], r_q[WIDTH-1:1]};
    if (r_is_div) begin
      w_acc_step = w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
      w_q_step   = {r_q[WIDTH-2:0], w_ge};
    end
    w_prod = {w_acc_step, w_q_step};
    if (r_neg_q) begin
      w_prod = ~w_prod + PW'(1);
    end
    w_hi_fix = w_prod[PW-1:WIDTH];
    w_lo_fix = w_prod[WIDTH-1:0];
    if (r_is_div) begin
      w_hi_fix = r_neg_r ? (~w_acc_step + WIDTH'(1)) : w_acc_step;
      w_lo_fix = r_neg_q ? (~w_q_step + WIDTH'(1)) : w_q_step;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_state_next = w_dz ? FIX : ITER;
      ITER:    if (w_last) w_state_next = FIX;
      FIX:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath: acc holds partial HI / remainder, q holds LO / quotient.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_q       <= '0;
      r_m       <= '0;
      r_cnt     <= '0;
      r_is_div  <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_divzero <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_m       <= w_abs_b;
            r_cnt     <= '0;
            r_is_div  <= w_div;
            r_neg_q   <= w_signed && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
            r_neg_r   <= w_signed && i_a[WIDTH-1];
            r_divzero <= w_dz;
            r_ovf     <= w_min_ovf;
            r_acc     <= w_dz ? i_a : '0;
            r_q       <= w_dz ? '1 : w_abs_a;
          end
        end
        ITER: begin
          r_cnt <= r_cnt + SH_W'(1);
          r_acc <= w_last ? w_hi_fix : w_acc_step;
          r_q   <= w_last ? w_lo_fix : w_q_step;
        end
        default: ;
      endcase
    end
  end

  assign o_busy    = (r_state != IDLE);
  assign o_done    = (r_state == FIX);
  assign o_hi      = r_acc;
  assign o_lo      = r_q;
  assign o_divzero = r_divzero;
  assign o_ovf     = r_ovf;

endmodule

// File: rtl/mips_alu_seq.sv
// Sequential MIPS ALU: single-cycle logic/arith/shift ops plus an iterative
// mul/div engine, with valid/ready handshakes on issue and result sides.
module mips_alu_seq
  import mips_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CTL_W = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CTL_W-1:0] ALUCtl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUOut,
  output logic             Zero,
  output logic             Overflow,
  output logic             DivZero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy
);

  localparam int unsigned SH_W = $clog2(WIDTH);

  logic [WIDTH-1:0] r_alu_out, r_hi, r_lo;
  logic             r_zero, r_ovf, r_divzero, r_out_valid;

  logic [OP_W-1:0]  w_op;
  logic             w_is_md, w_accept, w_start, w_single;
  logic [SH_W-1:0]  w_sh;
  logic [WIDTH-1:0] w_sum, w_diff, w_res;
  logic             w_ovf;
  logic             w_md_busy, w_md_done, w_md_divzero, w_md_ovf;
  logic [WIDTH-1:0] w_md_hi, w_md_lo;

  // Codes outside the 4-bit table behave like the reserved no-op code.
  assign w_op     = (32'(ALUCtl) > 32'd15) ? ALU_NOP : ALUCtl[OP_W-1:0];
  assign w_is_md  = is_muldiv(w_op);
  assign in_ready = RESET && !w_md_busy && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_start  = w_accept && w_is_md;
  assign w_single = w_accept && !w_is_md;

  assign w_sh   = B[SH_W-1:0];
  assign w_sum  = A + B;
  assign w_diff = A - B;

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    case (w_op)
      ALU_AND:  w_res = A & B;
      ALU_OR:   w_res = A | B;
      ALU_NOR:  w_res = ~(A | B);
      ALU_XOR:  w_res = A ^ B;
      ALU_ADD: begin
        w_res = w_sum;
        w_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
      end
      ALU_SUB: begin
        w_res = w_diff;
        w_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);
      end
      ALU_SLTU: w_res = WIDTH'(A < B);
      ALU_SLT:  w_res = WIDTH'($signed(A) < $signed(B));
      ALU_SLL:  w_res = A << w_sh;
      ALU_SRL:  w_res = A >> w_sh;
      ALU_SRA:  w_res = WIDTH'($signed(A) >>> w_sh);
      default:  ;
    endcase
  end

  mips_muldiv_unit #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk       (CLK),
    .rst_n     (RESET),
    .i_start   (w_start),
    .i_op      (w_op),
    .i_a       (A),
    .i_b       (B),
    .o_busy    (w_md_busy),
    .o_done    (w_md_done),
    .o_hi      (w_md_hi),
    .o_lo      (w_md_lo),
    .o_divzero (w_md_divzero),
    .o_ovf     (w_md_ovf)
  );

  // Result registers hold while the consumer stalls; a new single-cycle
  // accept on the draining edge replaces the result without a bubble.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_alu_out   <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
      r_divzero   <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_single) begin
      r_alu_out   <= w_res;
      r_zero      <= (w_res == '0);
      r_ovf       <= w_ovf;
      r_divzero   <= 1'b0;
      r_out_valid <= 1'b1;
    end else if (w_md_done) begin
      r_alu_out   <= w_md_lo;
      r_hi        <= w_md_hi;
      r_lo        <= w_md_lo;
      r_zero      <= (w_md_lo == '0);
      r_ovf       <= w_md_ovf;
      r_divzero   <= w_md_divzero;
      r_out_valid <= 1'b1;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign ALUOut    = r_alu_out;
  assign Zero      = r_zero;
  assign Overflow  = r_ovf;
  assign DivZero   = r_divzero;
  assign HI        = r_hi;
  assign LO        = r_lo;
  assign out_valid = r_out_valid;
  assign busy      = w_md_busy;

endmodule

// File: tb/tb_mips_alu_seq.sv
// Bench for mips_alu_seq: directed vectors, arithmetic reference model and
// a per-cycle scoreboard compare on the falling clock edge.
module tb_mips_alu_seq;

  localparam int unsigned W = 32;
  localparam logic [3:0] OP_AND = 4'd0, OP_OR = 4'd1, OP_ADD = 4'd2, OP_SLTU = 4'd3,
                         OP_SLL = 4'd4, OP_SRL = 4'd5, OP_SUB = 4'd6, OP_SLT = 4'd7,
                         OP_MULT = 4'd8, OP_MULTU = 4'd9, OP_DIV = 4'd10, OP_DIVU = 4'd11,
                         OP_NOR = 4'd12, OP_XOR = 4'd13, OP_SRA = 4'd14, OP_RSV = 4'd15;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic        CLK = 1'b0;
  logic        RESET, in_valid, out_ready;
  logic [3:0]  ALUCtl;
  logic [31:0] A, B;
  logic        in_ready, out_valid, Zero, Overflow, DivZero, busy;
  logic [31:0] ALUOut, HI, LO;

  mips_alu_seq #(.WIDTH(32), .CTL_W(4)) dut (
    .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready),
    .ALUCtl(ALUCtl), .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .ALUOut(ALUOut), .Zero(Zero), .Overflow(Overflow), .DivZero(DivZero),
    .HI(HI), .LO(LO), .busy(busy)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res, hi, lo;
    bit z, ovf, dz, md;
    int lat, due;
  } exp_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference results from plain integer arithmetic.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] cur_hi, input logic [31:0] cur_lo);
    exp_t e;
    longint sa, sb, s;
    logic [63:0] up;
    int sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b[4:0]);
    e.res = 32'd0; e.hi = cur_hi; e.lo = cur_lo;
    e.z = 1'b0; e.ovf = 1'b0; e.dz = 1'b0; e.md = 1'b0; e.lat = 1; e.due = 0;
    case (op)
      OP_AND:  e.res = a & b;
      OP_OR:   e.res = a | b;
      OP_NOR:  e.res = ~(a | b);
      OP_XOR:  e.res = a ^ b;
      OP_ADD:  begin s = sa + sb; e.res = s[31:0]; e.ovf = (s > SMAX) || (s < SMIN); end
      OP_SUB:  begin s = sa - sb; e.res = s[31:0]; e.ovf = (s > SMAX) || (s < SMIN); end
      OP_SLTU: e.res = (a < b) ? 32'd1 : 32'd0;
      OP_SLT:  e.res = (sa < sb) ? 32'd1 : 32'd0;
      OP_SLL:  e.res = a << sh;
      OP_SRL:  e.res = a >> sh;
      OP_SRA:  begin s = sa >>> sh; e.res = s[31:0]; end
      OP_MULT: begin s = sa * sb; e.hi = s[63:32]; e.lo = s[31:0]; e.md = 1'b1; end
      OP_MULTU: begin up = {32'd0, a} * {32'd0, b}; e.hi = up[63:32]; e.lo = up[31:0]; e.md = 1'b1; end
      OP_DIV, OP_DIVU: begin
        e.md = 1'b1;
        if (b == 32'd0) begin
          e.dz = 1'b1; e.lo = 32'hFFFF_FFFF; e.hi = a;
        end else if (op == OP_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.ovf = 1'b1; e.lo = 32'h8000_0000; e.hi = 32'd0;
        end else if (op == OP_DIV) begin
          s = sa / sb; e.lo = s[31:0];
          s = sa % sb; e.hi = s[31:0];
        end else begin
          e.lo = a / b; e.hi = a % b;
        end
      end
      default: ;
    endcase
    if (e.md) begin
      e.res = e.lo;
      e.lat = e.dz ? 2 : W + 2;
    end
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  exp_t sb_q[$];
  exp_t cur;
  bit exp_valid = 1'b0;
  bit consume_pend = 1'b0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;

  // Scoreboard compare, once per cycle on the falling edge.
  always @(negedge CLK) begin
    bit exp_busy, exp_ready;
    exp_t e;
    if (!RESET) begin
      check("reset_outputs", 32'({out_valid, busy, Zero, Overflow, DivZero, in_ready,
                                  |ALUOut, |HI, |LO}), 32'd0);
      sb_q.delete();
      exp_valid = 1'b0; consume_pend = 1'b0; m_hi = 32'd0; m_lo = 32'd0;
    end else begin
      if (consume_pend) exp_valid = 1'b0;
      if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
        cur = sb_q.pop_front();
        exp_valid = 1'b1;
      end
      check("out_valid", 32'(out_valid), 32'(exp_valid));
      if (exp_valid) begin
        check("ALUOut", ALUOut, cur.res);
        check("flags_z_ovf_dz", 32'({Zero, Overflow, DivZero}), 32'({cur.z, cur.ovf, cur.dz}));
        check("HI", HI, cur.hi);
        check("LO", LO, cur.lo);
      end
      exp_busy = (sb_q.size() > 0) && sb_q[0].md;
      check("busy", 32'(busy), 32'(exp_busy));
      exp_ready = !exp_busy && (!exp_valid || out_ready);
      check("in_ready", 32'(in_ready), 32'(exp_ready));
      consume_pend = exp_valid && out_ready;
      if (in_valid && exp_ready) begin
        e = model(ALUCtl, A, B, m_hi, m_lo);
        e.due = cyc + e.lat;
        if (e.md) begin m_hi = e.hi; m_lo = e.lo; end
        sb_q.push_back(e);
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bit got = 1'b0;
    ALUCtl = op; A = a; B = b; in_valid = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge CLK);
      if (in_ready) got = 1'b1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL issue_timeout: op %0d never accepted, required accept within 200 cycles", op);
    end
    @(posedge CLK); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    exp_t p;
    RESET = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    ALUCtl = 4'd0; A = 32'd0; B = 32'd0;

    // Hand-computed values that pin the reference model.
    p = model(OP_ADD, 32'd3, 32'd4, 0, 0);                  check("pin_add", p.res, 32'd7);
    p = model(OP_SUB, 32'd5, 32'd5, 0, 0);                  check("pin_sub_zero", 32'(p.z), 32'd1);
    p = model(OP_ADD, 32'h7FFF_FFFF, 32'd1, 0, 0);          check("pin_add_ovf", {p.res[31:1], p.ovf}, 32'h8000_0001);
    p = model(OP_SLT, 32'hFFFF_FFFF, 32'd1, 0, 0);          check("pin_slt", p.res, 32'd1);
    p = model(OP_SLTU, 32'hFFFF_FFFF, 32'd1, 0, 0);         check("pin_sltu", p.res, 32'd0);
    p = model(OP_SRA, 32'h8000_0000, 32'h24, 0, 0);         check("pin_sra", p.res, 32'hF800_0000);
    p = model(OP_SLL, 32'd1, 32'd31, 0, 0);                 check("pin_sll", p.res, 32'h8000_0000);
    p = model(OP_MULT, 32'hFFFF_FFFE, 32'd3, 0, 0);         check("pin_mult_hi", p.hi, 32'hFFFF_FFFF);
                                                            check("pin_mult_lo", p.lo, 32'hFFFF_FFFA);
                                                            check("pin_mult_lat", p.lat, 32'd34);
    p = model(OP_MULTU, 32'hFFFF_FFFE, 32'd3, 0, 0);        check("pin_multu_hi", p.hi, 32'd2);
    p = model(OP_DIVU, 32'd13, 32'd10, 0, 0);               check("pin_divu", {p.hi[15:0], p.lo[15:0]}, 32'h0003_0001);
    p = model(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0);          check("pin_div_q", p.lo, 32'hFFFF_FFFD);
                                                            check("pin_div_r", p.hi, 32'hFFFF_FFFF);
    p = model(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);  check("pin_div_min", {p.lo[31:1], p.ovf}, 32'h8000_0001);
    p = model(OP_DIV, 32'd5, 32'd0, 0, 0);                  check("pin_div0", {p.hi[15:0], 13'd0, p.dz, p.lat[1:0]}, 32'h0005_0006);

    idle(2);
    RESET = 1'b1;

    issue(OP_ADD, 32'd3, 32'd4);
    issue(OP_SUB, 32'd5, 32'd5);
    issue(OP_ADD, 32'h7FFF_FFFF, 32'd1);
    issue(OP_SUB, 32'h8000_0000, 32'd1);
    issue(OP_SLT, 32'hFFFF_FFFF, 32'd1);
    issue(OP_SLTU, 32'hFFFF_FFFF, 32'd1);
    issue(OP_SRA, 32'h8000_0000, 32'h24);
    issue(OP_SLL, 32'd1, 32'd31);
    issue(OP_SRL, 32'hFFFF_FFFF, 32'h21);
    issue(OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF);
    issue(OP_OR,  32'hF000_0000, 32'h0000_000F);
    issue(OP_NOR, 32'h0000_FFFF, 32'h00FF_0000);
    issue(OP_XOR, 32'hAAAA_5555, 32'hFFFF_0000);
    issue(OP_RSV, 32'h1234_5678, 32'h9ABC_DEF0);

    issue(OP_MULT,  32'hFFFF_FFFE, 32'd3);
    issue(OP_MULTU, 32'hFFFF_FFFE, 32'd3);
    issue(OP_DIVU,  32'd13, 32'd10);
    issue(OP_DIV,   32'hFFFF_FFF9, 32'd2);
    issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
    issue(OP_DIVU,  32'hFFFF_FFFF, 32'd7);
    issue(OP_DIV,   32'd7, 32'hFFFF_FFFE);
    issue(OP_MULT,  32'h8000_0000, 32'h8000_0000);
    issue(OP_DIV,   32'd5, 32'd0);
    issue(OP_ADD,   32'd1, 32'd1);

    // Consumer stall: result must hold and issue must be blocked.
    idle(2);
    out_ready = 1'b0;
    issue(OP_ADD, 32'd10, 32'd20);
    ALUCtl = OP_SUB; A = 32'd50; B = 32'd8; in_valid = 1'b1;
    idle(5);
    check("stall_hold", ALUOut, 32'd30);
    check("stall_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    issue(OP_SUB, 32'd50, 32'd8);

    // Reset in the middle of an iterating multiply.
    issue(OP_MULT, 32'h1234_5678, 32'h9ABC_DEF0);
    idle(10);
    RESET = 1'b0;
    idle(2);
    RESET = 1'b1;
    @(negedge CLK);
    check("ready_after_reset", 32'({in_ready, busy, out_valid}), 32'b100);
    @(posedge CLK); #1;
    issue(OP_ADD, 32'd2, 32'd2);

    for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge CLK);
    check("scoreboard_drain", 32'(sb_q.size()), 32'd0);
    idle(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
